// File: rtl/mux5_rr_scheduler.sv
// Round-robin scheduler for the 3-bit 5:1 selector datapath.
// Grants one of five requesters at a time, with bounded dwell under contention.
module mux5_rr_scheduler #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [4:0] REQ,
    output logic [4:0] GNT,
    output logic [2:0] SEL,
    output logic       BUSY,
    output logic [2:0] PTR
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    state_t           state;
    logic [4:0]       gnt;
    logic [2:0]       sel;
    logic             busy;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [4:0]       others;
    logic             hold;
    logic [2:0]       arb_all;
    logic [2:0]       arb_oth;
    logic             do_grant;
    logic             go_idle;
    logic [2:0]       g_idx;

    // First set mask bit searching from start, wrapping 4 -> 0.
    function automatic logic [2:0] arb(input logic [4:0] mask,
                                       input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
        return pick;
    endfunction

    function automatic logic [4:0] onehot(input logic [2:0] g);
        logic [4:0] v;
        v = 5'b00000;
        unique case (g)
            3'd0:    v = 5'b00001;
            3'd1:    v = 5'b00010;
            3'd2:    v = 5'b00100;
            3'd3:    v = 5'b01000;
            3'd4:    v = 5'b10000;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

    assign others  = REQ & ~gnt;
    assign hold    = |(REQ & gnt);
    assign arb_all = arb(REQ, ptr);
    assign arb_oth = arb(others, ptr);

    // Decide between regrant, preemption, idle return or holding.
    always_comb begin
        do_grant = 1'b0;
        go_idle  = 1'b0;
        g_idx    = arb_all;
        unique case (state)
            IDLE: begin
                do_grant = |REQ;
            end
            GRANT: begin
                if (!hold) begin
                    do_grant = |REQ;
                    go_idle  = ~|REQ;
                end else if (cnt == CNT_MAX && |others) begin
                    do_grant = 1'b1;
                    g_idx    = arb_oth;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    // Grant state machine with registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            gnt   <= 5'b00000;
            sel   <= 3'd0;
            busy  <= 1'b0;
            ptr   <= 3'd0;
            cnt   <= '0;
        end else if (do_grant) begin
            state <= GRANT;
            gnt   <= onehot(g_idx);
            sel   <= g_idx;
            busy  <= 1'b1;
            ptr   <= (g_idx == 3'd4) ? 3'd0 : g_idx + 3'd1;
            cnt   <= '0;
        end else if (go_idle) begin
            state <= IDLE;
            gnt   <= 5'b00000;
            busy  <= 1'b0;
        end else if (state == GRANT && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign GNT  = gnt;
    assign SEL  = sel;
    assign BUSY = busy;
    assign PTR  = ptr;

endmodule

// File: doc/mux5_rr_scheduler.md
Name: mux5_rr_scheduler

Overview:
- Round-robin scheduler that drives the select lines of the 3-bit 5:1 selector datapath.
- The selector sits on the board switch/LED top level. Five sources (U, V, W, X, Y; index 0..4) request access, and this block grants one at a time.
- It emits a one-hot grant and the matching 3-bit select code {S2,S1,S0}.
- A grant is held for a bounded dwell time when other sources contend, so every source gets fair, starvation-free access.

Parameters:
- DWELL, 4: max consecutive cycles a grant is held while another request is pending; legal range 1..255.
- CNT_W, 8: width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ  input  5  request per source; bit 0=U, 1=V, 2=W, 3=X, 4=Y; level-sensitive.
- GNT  output  5  one-hot grant, registered; all zero when idle.
- SEL  output  3  select code {S2,S1,S0} for the 5:1 selector; index 0..4 maps to 000, 001, 010, 011, 100.
- BUSY  output  1  high while a grant is active.
- PTR  output  3  round-robin pointer (debug/LED); next search start index, 0..4.

Behaviour:
- Reset (RESET_N=0, async, no clock needed):
  - state=IDLE; GNT=00000; SEL=000; BUSY=0; PTR=0; dwell counter CNT=0.
  - Deassertion takes effect at the next rising edge.
- Arbitration function ARB(mask):
  - Search order is PTR, PTR+1, … mod 5 (4 wraps to 0).
  - Picks the first index whose mask bit is set.
  - Pointer arithmetic is mod 5; values 5..7 never occur.
- On any grant to index g (registered):
  - GNT=onehot(g); SEL=code(g); BUSY=1.
  - PTR<=(g+1) mod 5; CNT<=0; state<=GRANT.
- IDLE:
  - If REQ≠0 at a rising edge, grant ARB(REQ). GNT is visible after that edge: 1-cycle latency.
  - Otherwise stay in IDLE. GNT=0, BUSY=0, SEL holds its last granted code.
- GRANT (holding index g), evaluated each rising edge in this priority order:
  1. REQ[g]=0 and REQ≠0: regrant ARB(REQ) on the same edge, with no idle bubble.
  2. REQ[g]=0 and REQ=0: go to IDLE; GNT<=0; BUSY<=0; SEL holds; PTR unchanged.
  3. REQ[g]=1, CNT=DWELL-1, and (REQ & ~onehot(g))≠0: preempt and grant ARB(REQ & ~onehot(g)).
  4. Otherwise hold the grant; CNT<=CNT+1, saturating at DWELL-1.
- Sole requester: a source that is the only requester keeps its grant indefinitely, with CNT saturated at DWELL-1.
- Late contender: a request arriving while CNT is saturated preempts on the next edge.
- DWELL=1: with contention, the grant rotates every cycle.
- Invariants:
  - GNT is always zero or one-hot.
  - GNT≠0 if and only if BUSY=1.
  - SEL always equals code(g) of the most recent grant.
- Reset mid-grant: all outputs return to reset values immediately. Arbitration restarts from PTR=0.
- Any REQ change is sampled only at clock edges. Glitches between edges have no effect.

Test Plan:
- Reset behaviour: assert RESET_N=0 mid-GRANT with no clock edge -> GNT=00000, SEL=000, BUSY=0, PTR=0 immediately. Release reset with REQ=00000 -> stays IDLE.
- Sole requester: after reset, REQ=00100 -> one edge later GNT=00100, SEL=010, BUSY=1, PTR=3. Hold REQ for 20 cycles -> grant unchanged (no preemption past DWELL).
- Full contention: REQ=11111 from reset, DWELL=4 -> grants 0,1,2,3,4,0,… each exactly 4 cycles. SEL sequence 000,001,010,011,100,000. No cycle with GNT=0.
- Early release: source 1 granted with REQ=01010; drop REQ[1] after 2 cycles -> next edge GNT=01000, SEL=011, no idle bubble.
- Wrap-around and ordering: PTR=4 (after granting 3), REQ=10001 -> grant 4 first (SEL=100), then 0 after DWELL cycles. PTR shows 0 then 1.
- Idle return: while granted to 2, drop all REQ -> next edge GNT=0, BUSY=0, SEL stays 010, PTR=3. A new REQ=00001 then grants 0.
